lsu_mem_ctrl: RTL and testbench

Load/store controller between the execute stage and the byte-addressed data memory. Accepts one load or store per handshake, decodes RV32 width/sign from funct3, performs read-modify-write for byte and halfword stores, and returns sign- or zero-extended load data. The data memory reads combinationally and always writes four bytes at `mem_addr` on the clock edge; this block supplies sub-word store semantics on top of it.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_load_extend.sv | 34 +++
 rtl/lsu_mem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit: RV32 funct3 encodings for
// memory accesses, the controller state type, the default data memory size
// and a helper that decides whether a funct3 is legal for a load or a store.
// Used by lsu_mem_ctrl and lsu_load_extend.

package lsu_pkg;

  localparam int LSU_N    = 32;
  localparam int LSU_A    = 32;
  localparam int LSU_SIZE = 16384;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RMW_READ  = 3'd2,
    ST_RMW_WRITE = 3'd3,
    ST_WRITE     = 3'd4,
    ST_RESP      = 3'd5
  } lsu_state_t;

  // Stores only have signed encodings; the unsigned forms exist for loads only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend
// Combinational load data formatter. Takes the raw memory word (byte 0 is the
// addressed byte) and the RV32 load funct3, and returns the sign- or
// zero-extended result. Shared with the writeback path.
//
// Ports:
//   funct3_i  in  3 : load funct3 (LB/LH/LW/LBU/LHU)
//   word_i    in  N : raw word read from memory
//   ext_o     out N : extended load value

module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int N = LSU_N
) (
  input  logic [2:0]   funct3_i,
  input  logic [N-1:0] word_i,
  output logic [N-1:0] ext_o
);

  // Select the low byte/halfword and extend it; anything else (LW and the
  // encodings the controller never lets through) passes the word unchanged.
  always_comb begin
    ext_o = word_i;
    case (funct3_i)
      F3_B:    ext_o = {{(N-8){word_i[7]}},  word_i[7:0]};
      F3_H:    ext_o = {{(N-16){word_i[15]}}, word_i[15:0]};
      F3_BU:   ext_o = {{(N-8){1'b0}},       word_i[7:0]};
      F3_HU:   ext_o = {{(N-16){1'b0}},      word_i[15:0]};
      default: ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
// Load/store controller between the execute stage and a byte-addressed data
// memory that reads combinationally and always writes a full word at
// mem_addr. Byte and halfword stores are done as read-modify-write so the
// untouched bytes of the word are preserved. One request in flight at a time.
//
// Configuration macro: LSU_BOUND_CHECK_EN
//   defined   : requests with req_addr >= SIZE-3 fault without touching memory
//   undefined : no bound check, the memory truncates the address itself
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_we                 1 = store, 0 = load
//   req_funct3             RV32 funct3 (width/sign)
//   req_addr               byte address
//   req_wdata              store data, LSB-aligned
//   resp_valid/resp_ready  response handshake
//   resp_rdata             extended load data, 0 for stores and faults
//   resp_fault             illegal funct3 or bound fault
//   mem_addr/mem_we        memory address and write enable
//   mem_wdata/mem_rdata    memory write word / combinational read word

module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int N    = LSU_N,
  parameter int A    = LSU_A,
  parameter int SIZE = LSU_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [A-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         resp_fault,
  output logic [A-1:0] mem_addr,
  output logic         mem_we,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

`ifdef LSU_BOUND_CHECK_EN
  localparam logic BOUND_EN = 1'b1;
`else
  localparam logic BOUND_EN = 1'b0;
`endif

  // The memory touches four bytes, so the last legal start address is SIZE-4.
  localparam logic [A-1:0] BOUND_LIMIT = A'(SIZE - 3);

  lsu_state_t   state_q, state_d;
  logic         we_q, we_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [A-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  // Byte 0 of the old word is always overwritten, so only the upper bytes are kept.
  logic [N-1:8] old_q, old_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         fault_q, fault_d;

  logic [N-1:0] ext_word;
  logic         bound_fault;

  assign bound_fault = BOUND_EN && (req_addr >= BOUND_LIMIT);

  lsu_load_extend #(.N(N)) u_load_extend (
    .funct3_i (funct3_q),
    .word_i   (mem_rdata),
    .ext_o    (ext_word)
  );

  // State and latched request registers. Memory strobes are decoded from
  // state_q, so an asynchronous reset also kills mem_we immediately and an
  // interrupted read-modify-write never reaches its write cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      old_q    <= old_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    old_d      = old_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          fault_d  = 1'b0;
          if (!f3_legal(req_we, req_funct3) || bound_fault) begin
            fault_d = 1'b1;
            state_d = ST_RESP;
          end else if (!req_we) begin
            state_d = ST_LOAD;
          end else if (req_funct3 == F3_W) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_READ;
          end
        end
      end

      ST_LOAD: begin
        mem_addr = addr_q;
        rdata_d  = ext_word;
        state_d  = ST_RESP;
      end

      ST_RMW_READ: begin
        mem_addr = addr_q;
        old_d    = mem_rdata[N-1:8];
        state_d  = ST_RMW_WRITE;
      end

      ST_RMW_WRITE: begin
        mem_addr = addr_q;
        mem_we   = 1'b1;
        if (funct3_q == F3_H) begin
          mem_wdata = {old_q[N-1:16], wdata_q[15:0]};
        end else begin
          mem_wdata = {old_q, wdata_q[7:0]};
        end
        state_d = ST_RESP;
      end

      ST_WRITE: begin
        mem_addr  = addr_q;
        mem_we    = 1'b1;
        mem_wdata = wdata_q;
        state_d   = ST_RESP;
      end

      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl
// Directed bench for lsu_mem_ctrl with a byte-array memory model that reads
// combinationally (little-endian, address wrapped to 14 bits) and writes four
// bytes on the clock edge when mem_we is high. Expected values are written
// out by hand in the step sequence below.

module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWe = 1'b0;
  logic [2:0]  reqFunct3 = 3'b000;
  logic [31:0] reqAddr = 32'h0;
  logic [31:0] reqWdata = 32'h0;
  logic        respValid;
  logic        respReady = 1'b0;
  logic [31:0] respRdata;
  logic        respFault;
  logic [31:0] memAddr;
  logic        memWe;
  logic [31:0] memWdata;
  logic [31:0] memRdata;

  int total = 0;
  int bad = 0;

  lsu_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_we     (reqWe),
    .req_funct3 (reqFunct3),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .resp_valid (respValid),
    .resp_ready (respReady),
    .resp_rdata (respRdata),
    .resp_fault (respFault),
    .mem_addr   (memAddr),
    .mem_we     (memWe),
    .mem_wdata  (memWdata),
    .mem_rdata  (memRdata)
  );

  always #5 clk = ~clk;

  // Memory model plus bookkeeping of every write: how many, on which edge,
  // and with what word.
  logic [7:0]  mem [0:16383];
  logic [13:0] a0;
  int          edgeNo = 0;
  int          weCount = 0;
  int          lastWeEdge = -1;
  logic [31:0] lastWeData = 32'h0;

  assign a0 = memAddr[13:0];
  assign memRdata = {mem[a0 + 14'd3], mem[a0 + 14'd2], mem[a0 + 14'd1], mem[a0]};

  always @(posedge clk) begin
    edgeNo <= edgeNo + 1;
    if (memWe) begin
      mem[a0]         <= memWdata[7:0];
      mem[a0 + 14'd1] <= memWdata[15:8];
      mem[a0 + 14'd2] <= memWdata[23:16];
      mem[a0 + 14'd3] <= memWdata[31:24];
      weCount    <= weCount + 1;
      lastWeEdge <= edgeNo + 1;
      lastWeData <= memWdata;
    end
  end

  // One comparison: counts it, and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request and return at the first falling edge where the
  // response is visible. lat counts falling edges after the accept edge.
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic fault,
                               output int lat, output int acceptEdge);
    @(negedge clk);
    checkOutput({tag, "_req_ready"}, {31'd0, reqReady}, 32'd1);
    reqValid  = 1'b1;
    reqWe     = we;
    reqFunct3 = f3;
    reqAddr   = addr;
    reqWdata  = wdata;
    @(posedge clk);
    #1;
    reqValid   = 1'b0;
    acceptEdge = edgeNo;
    @(negedge clk);
    lat = 0;
    while (!respValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_resp_seen"}, {31'd0, respValid}, 32'd1);
    rdata = respRdata;
    fault = respFault;
  endtask

  // Consume the pending response; called at a falling edge.
  task automatic finishResp();
    respReady = 1'b1;
    @(posedge clk);
    #1;
    respReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          acc;
    int          w0;

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready",  {31'd0, reqReady},  32'd1);
    checkOutput("rst_resp_valid", {31'd0, respValid}, 32'd0);
    checkOutput("rst_resp_rdata", respRdata,          32'd0);
    checkOutput("rst_resp_fault", {31'd0, respFault}, 32'd0);
    checkOutput("rst_mem_we",     {31'd0, memWe},     32'd0);
    checkOutput("rst_mem_addr",   memAddr,            32'd0);
    checkOutput("rst_mem_wdata",  memWdata,           32'd0);
    rst = 1'b0;

    // SW then LW of the same word; SW writes on the edge after accept.
    w0 = weCount;
    applyStimulus("sw100", 1'b1, F3_W, 32'h100, 32'hDEADBEEF, rd, flt, lat, acc);
    checkOutput("sw100_lat",     32'(lat),            32'd1);
    checkOutput("sw100_fault",   {31'd0, flt},        32'd0);
    checkOutput("sw100_rdata",   rd,                  32'd0);
    checkOutput("sw100_wecount", 32'(weCount - w0),   32'd1);
    checkOutput("sw100_weedge",  32'(lastWeEdge - acc), 32'd1);
    checkOutput("sw100_wedata",  lastWeData,          32'hDEADBEEF);
    finishResp();
    applyStimulus("lw100", 1'b0, F3_W, 32'h100, 32'h0, rd, flt, lat, acc);
    checkOutput("lw100_lat",   32'(lat),     32'd1);
    checkOutput("lw100_rdata", rd,           32'hDEADBEEF);
    checkOutput("lw100_fault", {31'd0, flt}, 32'd0);
    finishResp();

    // SB into an existing word: upper wdata bits must be ignored.
    applyStimulus("sw200", 1'b1, F3_W, 32'h200, 32'h11223344, rd, flt, lat, acc);
    finishResp();
    w0 = weCount;
    applyStimulus("sb200", 1'b1, F3_B, 32'h200, 32'h555555AA, rd, flt, lat, acc);
    checkOutput("sb200_lat",     32'(lat),            32'd2);
    checkOutput("sb200_wecount", 32'(weCount - w0),   32'd1);
    checkOutput("sb200_weedge",  32'(lastWeEdge - acc), 32'd2);
    checkOutput("sb200_wedata",  lastWeData,          32'h112233AA);
    checkOutput("sb200_rdata",   rd,                  32'd0);
    finishResp();
    applyStimulus("lw200a", 1'b0, F3_W, 32'h200, 32'h0, rd, flt, lat, acc);
    checkOutput("lw200a_rdata", rd, 32'h112233AA);
    finishResp();
    applyStimulus("sh200", 1'b1, F3_H, 32'h200, 32'h7777BEEF, rd, flt, lat, acc);
    checkOutput("sh200_lat", 32'(lat), 32'd2);
    finishResp();
    applyStimulus("lw200b", 1'b0, F3_W, 32'h200, 32'h0, rd, flt, lat, acc);
    checkOutput("lw200b_rdata", rd, 32'h1122BEEF);
    finishResp();

    // Load extension: 0x0000FF80 at 0x300, zero word at 0x304.
    applyStimulus("sw300", 1'b1, F3_W, 32'h300, 32'h0000FF80, rd, flt, lat, acc);
    finishResp();
    applyStimulus("sw304", 1'b1, F3_W, 32'h304, 32'h00000000, rd, flt, lat, acc);
    finishResp();
    applyStimulus("lb300", 1'b0, F3_B, 32'h300, 32'h0, rd, flt, lat, acc);
    checkOutput("lb300_rdata", rd, 32'hFFFFFF80);
    finishResp();
    applyStimulus("lbu300", 1'b0, F3_BU, 32'h300, 32'h0, rd, flt, lat, acc);
    checkOutput("lbu300_rdata", rd, 32'h00000080);
    finishResp();
    applyStimulus("lh300", 1'b0, F3_H, 32'h300, 32'h0, rd, flt, lat, acc);
    checkOutput("lh300_rdata", rd, 32'hFFFFFF80);
    finishResp();
    applyStimulus("lh301", 1'b0, F3_H, 32'h301, 32'h0, rd, flt, lat, acc);
    checkOutput("lh301_rdata", rd, 32'h000000FF);
    finishResp();
    applyStimulus("lhu300", 1'b0, F3_HU, 32'h300, 32'h0, rd, flt, lat, acc);
    checkOutput("lhu300_rdata", rd, 32'h0000FF80);
    finishResp();

    // Illegal funct3: fault on the accept edge, no write, data cleared.
    w0 = weCount;
    applyStimulus("ld011", 1'b0, 3'b011, 32'h300, 32'h0, rd, flt, lat, acc);
    checkOutput("ld011_lat",   32'(lat),     32'd0);
    checkOutput("ld011_fault", {31'd0, flt}, 32'd1);
    checkOutput("ld011_rdata", rd,           32'd0);
    finishResp();
    applyStimulus("st100", 1'b1, 3'b100, 32'h300, 32'h12345678, rd, flt, lat, acc);
    checkOutput("st100_lat",     32'(lat),          32'd0);
    checkOutput("st100_fault",   {31'd0, flt},      32'd1);
    checkOutput("fault_wecount", 32'(weCount - w0), 32'd0);
    finishResp();

    // Top-of-memory accesses.
`ifdef LSU_BOUND_CHECK_EN
    w0 = weCount;
    applyStimulus("lw3ffe", 1'b0, F3_W, 32'h3FFE, 32'h0, rd, flt, lat, acc);
    checkOutput("lw3ffe_fault", {31'd0, flt}, 32'd1);
    checkOutput("lw3ffe_lat",   32'(lat),     32'd0);
    finishResp();
    applyStimulus("sw3ffe", 1'b1, F3_W, 32'h3FFE, 32'h0BADF00D, rd, flt, lat, acc);
    checkOutput("sw3ffe_fault",   {31'd0, flt},      32'd1);
    checkOutput("sw3ffe_wecount", 32'(weCount - w0), 32'd0);
    finishResp();
`else
    applyStimulus("lw3ffe", 1'b0, F3_W, 32'h3FFE, 32'h0, rd, flt, lat, acc);
    checkOutput("lw3ffe_fault", {31'd0, flt}, 32'd0);
    finishResp();
`endif
    applyStimulus("lw3ffc", 1'b0, F3_W, 32'h3FFC, 32'h0, rd, flt, lat, acc);
    checkOutput("lw3ffc_fault", {31'd0, flt}, 32'd0);
    checkOutput("lw3ffc_lat",   32'(lat),     32'd1);
    finishResp();

    // Backpressure: response held for 5 cycles while a store is offered
    // and must be ignored.
    applyStimulus("lwbp", 1'b0, F3_W, 32'h100, 32'h0, rd, flt, lat, acc);
    checkOutput("lwbp_rdata", rd, 32'hDEADBEEF);
    w0 = weCount;
    reqValid  = 1'b1;
    reqWe     = 1'b1;
    reqFunct3 = F3_W;
    reqAddr   = 32'h100;
    reqWdata  = 32'h00000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_resp_valid", {31'd0, respValid}, 32'd1);
      checkOutput("bp_resp_rdata", respRdata,          32'hDEADBEEF);
      checkOutput("bp_req_ready",  {31'd0, reqReady},  32'd0);
    end
    reqValid = 1'b0;
    finishResp();
    @(negedge clk);
    checkOutput("bp_release_ready", {31'd0, reqReady},  32'd1);
    checkOutput("bp_release_valid", {31'd0, respValid}, 32'd0);
    checkOutput("bp_ignored_store", 32'(weCount - w0),  32'd0);
    applyStimulus("lw100b", 1'b0, F3_W, 32'h100, 32'h0, rd, flt, lat, acc);
    checkOutput("lw100b_rdata", rd, 32'hDEADBEEF);
    finishResp();

    // Reset during RMW_READ of an SB: nothing may be written.
    applyStimulus("sw400", 1'b1, F3_W, 32'h400, 32'hCAFEF00D, rd, flt, lat, acc);
    finishResp();
    w0 = weCount;
    @(negedge clk);
    reqValid  = 1'b1;
    reqWe     = 1'b1;
    reqFunct3 = F3_B;
    reqAddr   = 32'h400;
    reqWdata  = 32'h00000011;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    checkOutput("rmw_read_we", {31'd0, memWe}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_mem_we", {31'd0, memWe}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid_req_ready",  {31'd0, reqReady},  32'd1);
    checkOutput("rstmid_resp_valid", {31'd0, respValid}, 32'd0);
    checkOutput("rstmid_wecount",    32'(weCount - w0),  32'd0);
    rst = 1'b0;
    applyStimulus("lw400", 1'b0, F3_W, 32'h400, 32'h0, rd, flt, lat, acc);
    checkOutput("lw400_rdata", rd, 32'hCAFEF00D);
    finishResp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
